// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between ifetch and data ports
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_n;
    logic [LW-1:0]   lat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            owner_d;
    logic            i_eff, d_eff;
    logic            grant_i, grant_d, data_done;

    // During an ack cycle the acked requester is still driving its old request; mask it.
    always_comb begin
        i_eff     = i_req & ~i_ack;
        d_eff     = d_req & ~d_ack;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        data_done = 1'b0;
        state_n   = state;
        case (state)
            IDLE: begin
                if (d_eff && !(i_eff && starve_cnt == SW'(STARVE_LIMIT)))
                    grant_d = 1'b1;
                else if (i_eff)
                    grant_i = 1'b1;
                if (grant_d || grant_i)
                    state_n = ISSUE;
            end
            ISSUE: begin
                if (mem_ready)
                    state_n = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LW'(1)) begin
                    data_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (grant_d || grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= grant_d & d_we;
                mem_addr  <= grant_d ? d_addr : i_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
                owner_d   <= grant_d;
            end
            if (state == ISSUE && mem_ready) begin
                mem_req <= 1'b0;
                lat_cnt <= LW'(MEM_LATENCY);
            end
            if (state == WAIT)
                lat_cnt <= lat_cnt - LW'(1);
            // Writes wait out the same latency but leave the read registers alone.
            if (data_done) begin
                if (!mem_we) begin
                    if (owner_d)
                        d_rdata <= mem_rdata;
                    else
                        i_rdata <= mem_rdata;
                end
                i_ack <= ~owner_d;
                d_ack <= owner_d;
            end
            if (state == IDLE) begin
                if (grant_i || !i_req)
                    starve_cnt <= '0;
                else if (grant_d && i_eff && starve_cnt != SW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int SL  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_LATENCY (LAT),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Transaction-level model: absolute cycle stamps instead of FSM states.
    bit          busy;
    bit          own_d;
    bit          op_we;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_wdata;
    int          grant_cyc, acc_cyc, ack_cyc;
    bit          ack_d;
    logic [DW-1:0] e_irdata, e_drdata;
    int          starve;

    bit          i_pend = 0, d_pend = 0;
    bit          rd_fixed_en = 0;
    logic [DW-1:0] rd_fixed = '0;
    int          last_iack_cyc = -1, last_dack_cyc = -1;
    int          t0;
    logic [DW-1:0] saved;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy = 0; own_d = 0; op_we = 0; op_addr = '0; op_wdata = '0;
        grant_cyc = 0; acc_cyc = -1; ack_cyc = -10; ack_d = 0;
        e_irdata = '0; e_drdata = '0; starve = 0;
    endtask

    task automatic model_step(input int c);
        bit ie, de;
        if (busy) begin
            if (acc_cyc < 0) begin
                if (c > grant_cyc && mem_ready) acc_cyc = c;
            end else if (c == acc_cyc + LAT) begin
                if (!op_we) begin
                    if (own_d) e_drdata = mem_rdata;
                    else       e_irdata = mem_rdata;
                end
                busy = 0;
                ack_cyc = c + 1;
                ack_d = own_d;
            end
        end else begin
            ie = i_req && !(ack_cyc == c && !ack_d);
            de = d_req && !(ack_cyc == c && ack_d);
            if (de && !(ie && starve == SL)) begin
                busy = 1; own_d = 1; op_we = d_we; op_addr = d_addr; op_wdata = d_wdata;
                grant_cyc = c; acc_cyc = -1;
                if (ie) starve = (starve + 1 > SL) ? SL : starve + 1;
            end else if (ie) begin
                busy = 1; own_d = 0; op_we = 0; op_addr = i_addr; op_wdata = '0;
                grant_cyc = c; acc_cyc = -1;
                starve = 0;
            end
            if (!i_req) starve = 0;
        end
    endtask

    task automatic compare();
        bit e_mreq;
        e_mreq = busy && acc_cyc < 0 && cyc > grant_cyc;
        check("i_ack", {31'd0, i_ack}, {31'd0, (ack_cyc == cyc) && !ack_d});
        check("d_ack", {31'd0, d_ack}, {31'd0, (ack_cyc == cyc) && ack_d});
        check("i_rdata", i_rdata, e_irdata);
        check("d_rdata", d_rdata, e_drdata);
        check("mem_req", {31'd0, mem_req}, {31'd0, e_mreq});
        if (e_mreq) begin
            check("mem_we", {31'd0, mem_we}, {31'd0, op_we});
            check("mem_addr", mem_addr, op_addr);
            if (op_we) check("mem_wdata", mem_wdata, op_wdata);
        end
        if (i_ack === 1'b1) last_iack_cyc = cyc;
        if (d_ack === 1'b1) last_dack_cyc = cyc;
    endtask

    task automatic drive(input int pi, input int pd, input int pr);
        if (i_pend && ack_cyc == cyc - 1 && !ack_d) i_pend = 0;
        if (d_pend && ack_cyc == cyc - 1 && ack_d) d_pend = 0;
        if (!i_pend && int'($urandom_range(0, 99)) < pi) begin
            i_pend = 1;
            i_addr = $urandom;
        end
        if (!d_pend && int'($urandom_range(0, 99)) < pd) begin
            d_pend  = 1;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        i_req     = i_pend;
        d_req     = d_pend;
        mem_ready = int'($urandom_range(0, 99)) < pr;
        mem_rdata = rd_fixed_en ? rd_fixed : DW'($urandom);
    endtask

    task automatic run(input int n, input int pi, input int pd, input int pr);
        for (int k = 0; k < n; k++) begin
            drive(pi, pd, pr);
            @(negedge clk);
            compare();
            model_step(cyc);
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
        check({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single ifetch, memory always ready, fixed read word.
        t0 = cyc;
        rd_fixed_en = 1; rd_fixed = 32'h0000_0013;
        i_pend = 1; i_addr = 32'h100;
        run(8, 0, 0, 100);
        check("t1_iack_cyc", 32'(last_iack_cyc), 32'(t0 + 4));
        check("t1_i_rdata", i_rdata, 32'h13);
        rd_fixed_en = 0;

        // Simultaneous ifetch and data read: data goes first.
        i_pend = 1; i_addr = 32'h100;
        d_pend = 1; d_we = 0; d_addr = 32'h2000; d_wdata = '0;
        run(14, 0, 0, 100);
        check("t2_order", {31'd0, last_dack_cyc < last_iack_cyc}, 32'd1);

        // Data write leaves d_rdata alone.
        saved = e_drdata;
        d_pend = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
        run(8, 0, 0, 100);
        check("t4_d_rdata_kept", d_rdata, saved);

        // Memory stalls three cycles after mem_req rises.
        t0 = cyc;
        i_pend = 1; i_addr = 32'h104;
        run(1, 0, 0, 100);
        run(3, 0, 0, 0);
        run(6, 0, 0, 100);
        check("t5_iack_cyc", 32'(last_iack_cyc), 32'(t0 + 7));

        // Heavy contention, then mixed random traffic.
        run(150, 100, 100, 100);
        run(400, 30, 40, 70);
        run(30, 0, 0, 100);

        // Reset while the access is waiting on memory latency.
        i_pend = 1; i_addr = 32'h300;
        run(3, 0, 0, 100);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        i_pend = 0; d_pend = 0; i_req = 0; d_req = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(6, 0, 0, 100);
        t0 = cyc;
        i_pend = 1; i_addr = 32'h400;
        run(8, 0, 0, 100);
        check("t6_iack_cyc", 32'(last_iack_cyc), 32'(t0 + 4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
